// File: rtl/synapse_accumulator.sv
// Synapse accumulator: scans one spike vector per timestep, one synapse per cycle,
// summing signed weights of firing inputs into a saturated unsigned input current.
module synapse_accumulator #(
  parameter int N_INPUTS = 16,
  parameter int ADDR_W   = 4,
  parameter int WEIGHT_W = 16,
  parameter int CUR_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_INPUTS-1:0] spike_vec,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [WEIGHT_W-1:0] wr_data,
  output logic [CUR_W-1:0]    input_current,
  output logic                out_valid,
  output logic                busy,
  output logic [1:0]          state_dbg
);

  // Handshake: a spike vector transfers on the rising edge where in_valid and
  // in_ready are both high; in_valid while in_ready is low is ignored, so the
  // source holds spike_vec and in_valid until that edge.

  localparam int ACC_W = WEIGHT_W + ADDR_W + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_INPUTS - 1);

  logic [1:0]                state;
  logic [1:0]                state_next;
  logic [N_INPUTS-1:0]       spikes;
  logic [ADDR_W-1:0]         idx;
  logic signed [ACC_W-1:0]   acc;
  logic [WEIGHT_W-1:0]       weights [N_INPUTS];
  logic [WEIGHT_W-1:0]       scan_weight;
  logic signed [ACC_W-1:0]   scan_term;
  logic [CUR_W-1:0]          sat_current;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // The scan reads the registered weight, so a write landing on the same edge
  // as its index is scanned only affects later passes.
  assign scan_weight = weights[idx];
  assign scan_term   = {{(ACC_W-WEIGHT_W){scan_weight[WEIGHT_W-1]}}, scan_weight};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        weights[i] <= '0;
      end
    end else if (wr_en) begin
      weights[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = ACCUM;
      ACCUM:   if (idx == LAST_IDX) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Negative sums clamp to zero; anything above the current range pins at full scale.
  always_comb begin
    sat_current = acc[CUR_W-1:0];
    if (acc[ACC_W-1]) begin
      sat_current = '0;
    end else if (|acc[ACC_W-2:CUR_W]) begin
      sat_current = '1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      spikes        <= '0;
      idx           <= '0;
      acc           <= '0;
      input_current <= '0;
      out_valid     <= 1'b0;
    end else begin
      state     <= state_next;
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            spikes <= spike_vec;
            acc    <= '0;
            idx    <= '0;
          end
        end
        ACCUM: begin
          if (spikes[idx]) begin
            acc <= acc + scan_term;
          end
          idx <= idx + 1'b1;
        end
        DONE: begin
          input_current <= sat_current;
          out_valid     <= 1'b1;
        end
        default: begin
          idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_synapse_accumulator.sv
// Bench for synapse_accumulator: table of weight/spike vectors, hazard, streaming,
// reset-abort and random sequences, checked through an expected-result queue.
module tb_synapse_accumulator;

  logic        clk;
  logic        reset;
  logic [15:0] spike_vec;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [15:0] input_current;
  logic        out_valid;
  logic        busy;
  logic [1:0]  state_dbg;

  synapse_accumulator dut (
    .clk(clk), .reset(reset), .spike_vec(spike_vec), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .input_current(input_current), .out_valid(out_valid), .busy(busy),
    .state_dbg(state_dbg)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] spikes;
    int          fill;
    int          nw;
    int          wa [3];
    int          wd [3];
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs [8];
  int          w_model [16];
  logic [15:0] exp_q [$];
  int          hs_q [$];
  string       name_q [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_hs = 0;
  int          ov_count = 0;
  bit          hs_pend = 0;
  bit          prev_ov = 0;

  always @(posedge clk) begin
    cyc++;
    if (hs_pend) last_hs = cyc;
  end

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    hs_pend = in_valid && in_ready;
    if (busy) begin
      checks++;
      if (in_ready) begin
        errors++;
        $display("FAIL in_ready_busy: in_ready=%0d required 0 while busy", in_ready);
      end
    end
    if (out_valid) begin
      ov_count++;
      checks++;
      if (prev_ov) begin
        errors++;
        $display("FAIL ov_width: out_valid high two cycles in a row, required one");
      end
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ov: out_valid=1 with no result pending, required 0");
      end else begin
        logic [15:0] e;
        int          h;
        string       n;
        e = exp_q.pop_front();
        h = hs_q.pop_front();
        n = name_q.pop_front();
        checks += 2;
        if (input_current !== e) begin
          errors++;
          $display("FAIL current[%s]: got %0d required %0d", n, input_current, e);
        end
        if (cyc - h != 17) begin
          errors++;
          $display("FAIL latency[%s]: got %0d cycles required 17", n, cyc - h);
        end
      end
    end
    prev_ov = out_valid;
  end

  function automatic logic [15:0] model_current(logic [15:0] s);
    int sum;
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      if (s[i]) sum += w_model[i];
    end
    if (sum < 0) return 16'd0;
    if (sum > 65535) return 16'hFFFF;
    return sum[15:0];
  endfunction

  // driver tasks: entered and left at posedge+2
  task automatic write_weight(input int addr, input int data);
    wr_en   = 1'b1;
    wr_addr = addr[3:0];
    wr_data = data[15:0];
    w_model[addr] = data;
    @(posedge clk); #2;
    wr_en = 1'b0;
  endtask

  task automatic fill_weights(input int v);
    for (int a = 0; a < 16; a++) write_weight(a, v);
  endtask

  task automatic send_vec(input logic [15:0] s, input logic [15:0] e, input string n);
    bit ok;
    ok = 0;
    spike_vec = s;
    in_valid  = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL handshake[%s]: in_ready=0 after 100 cycles, required 1", n);
      in_valid = 1'b0;
      @(posedge clk); #2;
      return;
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
    exp_q.push_back(e);
    hs_q.push_back(last_hs);
    name_q.push_back(n);
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results pending after 200 cycles, required 0", exp_q.size());
      exp_q.delete();
      hs_q.delete();
      name_q.delete();
    end
    @(posedge clk); #2;
  endtask

  task automatic check_val(input string n, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", n, got, req);
    end
  endtask

  initial begin
    int hs_times [3];
    int ov_before;

    vecs[0] = '{"zero_w",    16'hFFFF, 0,    0, '{0, 0, 0},  '{0, 0, 0},            16'd0};
    vecs[1] = '{"basic",     16'h8009, 0,    3, '{0, 3, 15}, '{1000, 2500, 6500},   16'd10000};
    vecs[2] = '{"pos_sat",   16'h0007, 30000, 0, '{0, 0, 0}, '{0, 0, 0},            16'd65535};
    vecs[3] = '{"neg_clamp", 16'h0006, 0,    2, '{1, 2, 0},  '{-20000, 5000, 0},    16'd0};
    vecs[4] = '{"inhibit",   16'h0006, 0,    2, '{1, 2, 0},  '{-2000, 5000, 0},     16'd3000};
    vecs[5] = '{"no_spikes", 16'h0000, 1234, 0, '{0, 0, 0},  '{0, 0, 0},            16'd0};
    vecs[6] = '{"edge_max",  16'h0007, 0,    3, '{0, 1, 2},  '{32767, 32767, 1},    16'd65535};
    vecs[7] = '{"edge_neg1", 16'h0003, 0,    2, '{0, 1, 0},  '{-1, 0, 0},           16'd0};

    for (int i = 0; i < 16; i++) w_model[i] = 0;
    reset     = 1'b0;
    spike_vec = '0;
    in_valid  = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    @(negedge clk);
    check_val("reset_current", input_current, 0);
    check_val("reset_out_valid", out_valid, 0);
    check_val("reset_in_ready", in_ready, 1);
    check_val("reset_busy", busy, 0);
    @(posedge clk); #2;

    // table-driven vectors
    for (int t = 0; t < 8; t++) begin
      if (t != 0) fill_weights(vecs[t].fill);
      for (int j = 0; j < vecs[t].nw; j++) write_weight(vecs[t].wa[j], vecs[t].wd[j]);
      send_vec(vecs[t].spikes, vecs[t].exp, vecs[t].name);
      wait_drain();
    end

    // write hazards: w[10] written while index 4 scans, w[5] on the edge index 5 scans
    fill_weights(0);
    write_weight(5, 100);
    write_weight(10, 200);
    send_vec(16'h0420, 16'd400, "hazard");
    repeat (4) @(posedge clk);
    #2;
    wr_en = 1'b1; wr_addr = 4'd10; wr_data = 16'd300;
    @(posedge clk); #2;
    wr_addr = 4'd5; wr_data = 16'd777;
    @(posedge clk); #2;
    wr_en = 1'b0;
    w_model[10] = 300;
    w_model[5]  = 777;
    wait_drain();

    // continuous in_valid: one vector per 18 cycles
    spike_vec = 16'h0420;
    in_valid  = 1'b1;
    for (int j = 0; j < 3; j++) begin
      bit ok;
      ok = 0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (in_ready) begin
          ok = 1;
          break;
        end
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL stream_hs: in_ready=0 after 100 cycles, required 1");
        break;
      end
      @(posedge clk); #2;
      hs_times[j] = last_hs;
      exp_q.push_back(16'd1077);
      hs_q.push_back(last_hs);
      name_q.push_back("stream");
      if (j > 0) check_val("stream_spacing", hs_times[j] - hs_times[j-1], 18);
    end
    in_valid = 1'b0;
    wait_drain();

    // reset in the middle of a pass
    fill_weights(1000);
    send_vec(16'hFFFF, 16'd16000, "aborted");
    repeat (8) @(posedge clk);
    #2 reset = 1'b0;
    void'(exp_q.pop_back());
    void'(hs_q.pop_back());
    void'(name_q.pop_back());
    for (int i = 0; i < 16; i++) w_model[i] = 0;
    ov_before = ov_count;
    #1;
    check_val("abort_busy", busy, 0);
    check_val("abort_current", input_current, 0);
    check_val("abort_out_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    check_val("abort_no_pulse", ov_count - ov_before, 0);
    send_vec(16'hFFFF, model_current(16'hFFFF), "after_reset");
    wait_drain();

    // random weights and spike patterns against the model
    for (int r = 0; r < 6; r++) begin
      logic [15:0] s;
      for (int j = 0; j < 6; j++) begin
        write_weight($urandom_range(0, 15), int'($urandom_range(0, 65535)) - 32768);
      end
      s = 16'($urandom_range(0, 65535));
      send_vec(s, model_current(s), "random");
      wait_drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
